// File: rtl/argmax_decision.sv
// Argmax decision stage: collects per-class sums, scans them one lane per cycle,
// and hands the winning class over a valid/ready port. ARGMAX_MARGIN_EN adds margin_out.
//
// state   | meaning
// --------+------------------------------------------------------------
// COLLECT | capturing lane sums until every lane has reported
// SCAN    | sequential signed compare, one lane per clock
// DONE    | result presented, waiting for out_ready
module argmax_decision #(
    parameter int N_MATS     = 10,
    parameter int DATA_WIDTH = 16,
    parameter int IDX_W      = $clog2(N_MATS)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [N_MATS-1:0]                  valid_in,
    input  logic [N_MATS-1:0][DATA_WIDTH-1:0]  sum_in,
    output logic                               in_ready,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [IDX_W-1:0]                   class_out,
    output logic [DATA_WIDTH-1:0]              score_out,
`ifdef ARGMAX_MARGIN_EN
    output logic [DATA_WIDTH-1:0]              margin_out,
`endif
    output logic                               overrun
);

    typedef enum logic [1:0] {COLLECT, SCAN, DONE} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_MATS - 1);

    state_t                            state_q, state_d;
    logic [N_MATS-1:0]                 got_q, got_d;
    logic [N_MATS-1:0][DATA_WIDTH-1:0] lane_buf_q, lane_buf_d;
    logic [DATA_WIDTH-1:0]             best_q, best_d;
    logic [IDX_W-1:0]                  best_idx_q, best_idx_d;
    logic [IDX_W-1:0]                  idx_q, idx_d;
    logic                              overrun_q, overrun_d;
    logic [IDX_W-1:0]                  class_q, class_d;
    logic [DATA_WIDTH-1:0]             score_q, score_d;
    logic [N_MATS-1:0]                 fresh;
    logic [N_MATS-1:0]                 full;
    logic [DATA_WIDTH-1:0]             cand;
`ifdef ARGMAX_MARGIN_EN
    logic [DATA_WIDTH-1:0]             runner_q, runner_d;
    logic [DATA_WIDTH-1:0]             margin_q, margin_d;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= COLLECT;
            got_q      <= '0;
            lane_buf_q <= '0;
            best_q     <= '0;
            best_idx_q <= '0;
            idx_q      <= '0;
            overrun_q  <= 1'b0;
            class_q    <= '0;
            score_q    <= '0;
`ifdef ARGMAX_MARGIN_EN
            runner_q   <= '0;
            margin_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            got_q      <= got_d;
            lane_buf_q <= lane_buf_d;
            best_q     <= best_d;
            best_idx_q <= best_idx_d;
            idx_q      <= idx_d;
            overrun_q  <= overrun_d;
            class_q    <= class_d;
            score_q    <= score_d;
`ifdef ARGMAX_MARGIN_EN
            runner_q   <= runner_d;
            margin_q   <= margin_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        got_d      = got_q;
        lane_buf_d = lane_buf_q;
        best_d     = best_q;
        best_idx_d = best_idx_q;
        idx_d      = idx_q;
        overrun_d  = overrun_q;
        class_d    = class_q;
        score_d    = score_q;
`ifdef ARGMAX_MARGIN_EN
        runner_d   = runner_q;
        margin_d   = margin_q;
`endif
        fresh      = valid_in & ~got_q;
        full       = got_q | valid_in;
        cand       = lane_buf_q[idx_q];

        case (state_q)
            COLLECT: begin
                for (int i = 0; i < N_MATS; i++) begin
                    if (fresh[i]) lane_buf_d[i] = sum_in[i];
                end
                got_d = full;
                if (|(valid_in & got_q)) overrun_d = 1'b1;
                if (&full) begin
                    state_d    = SCAN;
                    // lane 0 may be landing on this very edge, so bypass the buffer
                    best_d     = fresh[0] ? sum_in[0] : lane_buf_q[0];
                    best_idx_d = '0;
                    idx_d      = IDX_W'(1);
                end
            end
            SCAN: begin
                if (|valid_in) overrun_d = 1'b1;
`ifdef ARGMAX_MARGIN_EN
                if ($signed(cand) > $signed(best_q)) begin
                    runner_d   = best_q;
                    best_d     = cand;
                    best_idx_d = idx_q;
                end else if (idx_q == IDX_W'(1) || $signed(cand) > $signed(runner_q)) begin
                    runner_d   = cand;
                end
`else
                if ($signed(cand) > $signed(best_q)) begin
                    best_d     = cand;
                    best_idx_d = idx_q;
                end
`endif
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                    class_d = best_idx_d;
                    score_d = best_d;
`ifdef ARGMAX_MARGIN_EN
                    // best >= runner-up, so the modular difference is the true margin
                    margin_d = best_d - runner_d;
`endif
                end
            end
            DONE: begin
                if (|valid_in) overrun_d = 1'b1;
                if (out_ready) begin
                    state_d = COLLECT;
                    got_d   = '0;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    assign in_ready   = (state_q == COLLECT);
    assign out_valid  = (state_q == DONE);
    assign class_out  = class_q;
    assign score_out  = score_q;
    assign overrun    = overrun_q;
`ifdef ARGMAX_MARGIN_EN
    assign margin_out = margin_q;
`endif

endmodule

// File: tb/tb_argmax_decision.sv
// Directed bench for argmax_decision; margin checks are active when ARGMAX_MARGIN_EN is defined.
module tb_argmax_decision;

    localparam int N  = 10;
    localparam int DW = 16;
    localparam int IW = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [N-1:0]          valid_in;
    logic [N-1:0][DW-1:0]  sum_in;
    logic                  in_ready;
    logic                  out_valid;
    logic                  out_ready;
    logic [IW-1:0]         class_out;
    logic [DW-1:0]         score_out;
    logic [DW-1:0]         margin_out;
    logic                  overrun;

    int n_cmp = 0;
    int n_err = 0;
    int lat;

    always #5 clk = ~clk;

`ifndef ARGMAX_MARGIN_EN
    assign margin_out = '0;
`endif

    argmax_decision #(.N_MATS(N), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .sum_in    (sum_in),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .class_out (class_out),
        .score_out (score_out),
`ifdef ARGMAX_MARGIN_EN
        .margin_out(margin_out),
`endif
        .overrun   (overrun)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_margin(input string tag, input logic [31:0] exp);
`ifdef ARGMAX_MARGIN_EN
        check(tag, 32'(margin_out), exp);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until out_valid is seen, bounded so the run cannot hang.
    task automatic wait_out(output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
    endtask

    initial begin
        rst       = 1'b0;
        valid_in  = '0;
        sum_in    = '0;
        out_ready = 1'b0;
        tick();
        tick();
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_class",     32'(class_out), 32'd0);
        check("rst_score",     32'(score_out), 32'd0);
        check("rst_overrun",   32'(overrun),   32'd0);
        check_margin("rst_margin", 32'd0);
        rst = 1'b1;
        tick();

        // all lanes at once, lane i = i
        valid_in = '1;
        for (int i = 0; i < N; i++) sum_in[i] = 16'(i);
        tick();
        valid_in = '0;
        check("t1_in_ready_low", 32'(in_ready), 32'd0);
        wait_out(lat);
        check("t1_latency", 32'(lat),       32'd9);
        check("t1_class",   32'(class_out), 32'd9);
        check("t1_score",   32'(score_out), 32'h0009);
        check_margin("t1_margin", 32'd1);

        // hold off acceptance for 20 cycles
        for (int c = 0; c < 20; c++) begin
            tick();
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_class", 32'(class_out), 32'd9);
            check("hold_score", 32'(score_out), 32'h0009);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("acc_out_valid", 32'(out_valid), 32'd0);
        check("acc_in_ready",  32'(in_ready),  32'd1);
        check("acc_class_held", 32'(class_out), 32'd9);
        check("acc_score_held", 32'(score_out), 32'h0009);

        // staggered arrival 9..0, lane 3 is the peak
        for (int k = N - 1; k >= 0; k--) begin
            valid_in = '0;
            valid_in[k] = 1'b1;
            sum_in[k] = (k == 3) ? 16'h7FFF : 16'h0100;
            tick();
            if (k > 0) begin
                check("t2_no_early_valid", 32'(out_valid), 32'd0);
                check("t2_in_ready",       32'(in_ready),  32'd1);
            end
        end
        valid_in = '0;
        check("t2_in_ready_low", 32'(in_ready), 32'd0);
        wait_out(lat);
        check("t2_latency", 32'(lat),       32'd9);
        check("t2_class",   32'(class_out), 32'd3);
        check("t2_score",   32'(score_out), 32'h7FFF);
        check_margin("t2_margin", 32'h7EFF);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("t2_accept", 32'(out_valid), 32'd0);

        // signed values with a tie; out_ready held through SCAN
        for (int i = 0; i < N; i++) sum_in[i] = (i == 5 || i == 7) ? 16'h0002 : 16'hFFFF;
        valid_in = '1;
        tick();
        valid_in  = '0;
        out_ready = 1'b1;
        wait_out(lat);
        check("t3_latency", 32'(lat),       32'd9);
        check("t3_class",   32'(class_out), 32'd5);
        check("t3_score",   32'(score_out), 32'h0002);
        check_margin("t3_margin", 32'd0);
        tick();
        out_ready = 1'b0;
        check("t3_accept_valid", 32'(out_valid), 32'd0);
        check("t3_accept_ready", 32'(in_ready),  32'd1);
        check("t3_no_overrun",   32'(overrun),   32'd0);

        // duplicate lane 2 before the set completes
        sum_in = '0;
        valid_in = 10'b00_0000_0100;
        sum_in[2] = 16'h0010;
        tick();
        check("t4_first_ok", 32'(overrun), 32'd0);
        sum_in[2] = 16'h0FFF;
        tick();
        check("t4_overrun", 32'(overrun), 32'd1);
        valid_in = 10'b11_1111_1011;
        tick();
        valid_in = '0;
        wait_out(lat);
        check("t4_latency", 32'(lat),       32'd9);
        check("t4_class",   32'(class_out), 32'd2);
        check("t4_score",   32'(score_out), 32'h0010);
        check_margin("t4_margin", 32'h0010);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("t4_sticky", 32'(overrun), 32'd1);

        // reset asserted in the middle of SCAN
        for (int i = 0; i < N; i++) sum_in[i] = (i == 4) ? 16'h0500 : 16'h0001;
        valid_in = '1;
        tick();
        valid_in = '0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("t5_rst_in_ready",  32'(in_ready),  32'd1);
        check("t5_rst_out_valid", 32'(out_valid), 32'd0);
        check("t5_rst_class",     32'(class_out), 32'd0);
        check("t5_rst_score",     32'(score_out), 32'd0);
        check("t5_rst_overrun",   32'(overrun),   32'd0);
        check_margin("t5_rst_margin", 32'd0);
        tick();
        rst = 1'b1;
        tick();

        // fresh set in two halves after the reset
        for (int i = 0; i < N; i++) sum_in[i] = (i == 6) ? 16'h0200 : 16'h0001;
        valid_in = 10'b00_0001_1111;
        tick();
        check("t5_partial_ready", 32'(in_ready),  32'd1);
        check("t5_partial_valid", 32'(out_valid), 32'd0);
        valid_in = 10'b11_1110_0000;
        tick();
        valid_in = '0;
        wait_out(lat);
        check("t5_latency", 32'(lat),       32'd9);
        check("t5_class",   32'(class_out), 32'd6);
        check("t5_score",   32'(score_out), 32'h0200);
        check("t5_overrun", 32'(overrun),   32'd0);
        check_margin("t5_margin", 32'h01FF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/argmax_decision.md
# argmax_decision

Classification decision stage directly downstream of the parallel reduction array. It captures the N_MATS per-class sums as each lane's valid bit fires. Once every lane has reported, it runs a sequential argmax scan that compares one lane per cycle. It then presents the winning class index and score on a valid/ready output handshake toward the result/UART path.

## Interface
- N_MATS, 10, number of class lanes; ≥2
- DATA_WIDTH, 16, width of each class sum; signed two's complement
- IDX_W, $clog2(N_MATS), width of class index (derived)

- clk  in  1  single system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset; all state cleared while low
- valid_in  in  N_MATS  per-lane strobe; bit i high means sum_in[i] is valid this cycle
- sum_in  in  DATA_WIDTH x N_MATS  per-lane class sums from the reduction array
- in_ready  out  1  high while in COLLECT (status only; upstream has no stall)
- out_valid  out  1  result valid; held until accepted
- out_ready  in  1  downstream accepts result
- class_out  out  IDX_W  winning class index
- score_out  out  DATA_WIDTH  winning sum
- margin_out  out  DATA_WIDTH  unsigned best minus runner-up; present only with ARGMAX_MARGIN_EN
- overrun  out  1  sticky error: a sum arrived that could not be accepted

## Operation
- States: COLLECT (reset state), SCAN, DONE.
- COLLECT:
  - Each lane i with valid_in[i]=1 and got[i]=0 is written into buf[i], and got[i] is set.
  - Multiple lanes may capture on the same edge.
  - valid_in[i]=1 with got[i]=1 drops the new value, keeps the old one, and sets overrun.
- On the edge where got becomes all-ones, including lanes captured on that same edge, the state goes to SCAN.
  - That edge loads best=buf[0] (or the sum_in[0] being captured), best_idx=0 and idx=1.
- SCAN: each edge compares buf[idx] with best using a signed compare.
  - A strictly greater value replaces best and best_idx.
  - idx increments.
  - After idx=N_MATS-1 is processed, the state goes to DONE.
- Ties go to the lowest index.
- DONE: out_valid=1, and class_out/score_out/margin_out are stable.
  - On an edge with out_valid && out_ready, the state goes to COLLECT and got is cleared.
  - class_out/score_out are not cleared on acceptance. They hold their last values.
- In SCAN/DONE, any valid_in bit is dropped and sets overrun.
- overrun clears only on reset.
- Reset mid-operation: immediate return to COLLECT with all outputs cleared. A partial capture is discarded.

## Timing
- Reset values: in_ready=1, out_valid=0, class_out=0, score_out=0, margin_out=0, overrun=0.
- Let edge E be the edge that captures the final outstanding lane.
  - out_valid rises at edge E+N_MATS-1 (9 cycles for N_MATS=10).
  - in_ready falls at edge E.
- Acceptance at edge A drops out_valid and raises in_ready at edge A.
  - valid_in present in the cycle before edge A (state DONE) is dropped and flags overrun.
- out_ready held high in SCAN has no effect until DONE.
- Outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- ARGMAX_MARGIN_EN defined:
  - A runner-up register tracks the second-largest value under the same compare and tie rules. When a new best is found, the old best becomes the runner-up.
  - buf[0] seeds best. The runner-up seeds from buf[1] on the first SCAN step.
  - margin_out = best − runner-up, as an unsigned DATA_WIDTH value. This always fits because the difference is non-negative and at most 2^DATA_WIDTH−1.
- ARGMAX_MARGIN_EN undefined: margin_out port and runner-up logic are absent. All other behaviour is identical.

## Test plan
- Reset, then all 10 lanes valid in one cycle with sums 0..9 (lane i = i) → out_valid 9 cycles later; class_out=9, score_out=9, margin_out=1.
- Lanes arrive staggered one per cycle in order 9..0 with values lane3=0x7FFF and others 0x0100 → no result before lane 0 arrives; class_out=3, score_out=0x7FFF, margin_out=0x7EFF.
- Signed/tie case with all lanes 0xFFFF (−1) except lanes 5 and 7 = 0x0002 → class_out=5 (lowest index wins the tie); margin_out=0.
- out_ready held low for 20 cycles in DONE → out_valid and outputs stable throughout.
  - Then a 1-cycle out_ready pulse → out_valid=0 and in_ready=1 next cycle.
  - A second full set then yields a fresh result.
- Lane 2 valid twice before the set completes (first 0x0010, then 0x0FFF), others 0 → overrun=1, lane 2 keeps 0x0010, class_out=2.
- Assert rst during SCAN → all outputs return to reset values.
  - After release, a full new set produces a correct result with no stale lane data.
